// File: rtl/bit_unstuffer_if.sv
// Signal bundle between the NRZI decoder, the bit unstuffer and the byte assembler.
interface bit_unstuffer_if;
  logic       s_in;
  logic       start_unstuffer;
  logic       end_unstuffer;
  logic       abort;
  logic       s_out;
  logic       bit_valid;
  logic       start_out;
  logic       end_out;
  logic       byte_done;
  logic [2:0] bit_cnt;
  logic       stuff_err;
  logic       align_err;
  logic       busy;

  modport master (
    output s_in, start_unstuffer, end_unstuffer, abort,
    input  s_out, bit_valid, start_out, end_out, byte_done, bit_cnt,
           stuff_err, align_err, busy
  );

  modport slave (
    input  s_in, start_unstuffer, end_unstuffer, abort,
    output s_out, bit_valid, start_out, end_out, byte_done, bit_cnt,
           stuff_err, align_err, busy
  );
endinterface

// File: rtl/bit_unstuffer.sv
// Removes the stuffed 0 after every MAX_ONES consecutive 1s, tracks byte
// alignment and reports stuffing/alignment errors; all outputs registered.
module bit_unstuffer #(
  parameter int MAX_ONES = 6,
  parameter int CNT_W    = 3
) (
  input logic           clk,
  input logic           rst_n,
  bit_unstuffer_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] ONES_LIMIT = CNT_W'(MAX_ONES);

  logic [0:0]       state;
  logic [CNT_W-1:0] ones_cnt;
  logic [2:0]       bit_cnt;
  logic             s_out;
  logic             bit_valid;
  logic             start_out;
  logic             end_out;
  logic             byte_done;
  logic             stuff_err;
  logic             align_err;

  // Priority inside RUN: abort > end > restart > data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      s_out     <= 1'b0;
      bit_valid <= 1'b0;
      start_out <= 1'b0;
      end_out   <= 1'b0;
      byte_done <= 1'b0;
      stuff_err <= 1'b0;
      align_err <= 1'b0;
    end else begin
      s_out     <= 1'b0;
      bit_valid <= 1'b0;
      start_out <= 1'b0;
      end_out   <= 1'b0;
      byte_done <= 1'b0;
      stuff_err <= 1'b0;
      align_err <= 1'b0;

      if (bus.abort) begin
        state    <= IDLE;
        ones_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == IDLE) begin
        if (bus.start_unstuffer) begin
          state     <= RUN;
          start_out <= 1'b1;
          ones_cnt  <= '0;
          bit_cnt   <= '0;
        end
      end else if (bus.end_unstuffer) begin
        state     <= IDLE;
        end_out   <= 1'b1;
        align_err <= (bit_cnt != 3'd0);
        ones_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (bus.start_unstuffer) begin
        start_out <= 1'b1;
        ones_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (ones_cnt == ONES_LIMIT) begin
        // This slot must hold the stuffed 0; a 1 here kills the packet.
        if (bus.s_in) begin
          stuff_err <= 1'b1;
          state     <= IDLE;
          bit_cnt   <= '0;
        end
        ones_cnt <= '0;
      end else begin
        bit_valid <= 1'b1;
        s_out     <= bus.s_in;
        ones_cnt  <= bus.s_in ? ones_cnt + CNT_W'(1) : '0;
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  assign bus.s_out     = s_out;
  assign bus.bit_valid = bit_valid;
  assign bus.start_out = start_out;
  assign bus.end_out   = end_out;
  assign bus.byte_done = byte_done;
  assign bus.bit_cnt   = bit_cnt;
  assign bus.stuff_err = stuff_err;
  assign bus.align_err = align_err;
  assign bus.busy      = (state == RUN);

endmodule

// File: tb/tb_bit_unstuffer.sv
// Self-checking bench for bit_unstuffer: vector table driven through a
// scoreboard queue, plus a two-byte stream with a bit-order scoreboard.
module tb_bit_unstuffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_unstuffer_if bus();

  bit_unstuffer #(.MAX_ONES(6), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        r;
    logic        st;
    logic        en;
    logic        ab;
    logic        d;
    logic [10:0] e;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] sb[$];
  logic        bit_sb[$];
  int          total = 0;
  int          bad = 0;

  // Expected-output packing: {bit_valid, s_out, start_out, end_out, byte_done,
  // bit_cnt, stuff_err, align_err, busy}; s_out is only compared when valid.
  function automatic logic [10:0] ex(input logic bv, so, sto, eo, bd,
                                     input logic [2:0] bc,
                                     input logic se, ae, bz);
    return {bv, so, sto, eo, bd, bc, se, ae, bz};
  endfunction

  function automatic logic [10:0] actual();
    return {bus.bit_valid, bus.bit_valid & bus.s_out, bus.start_out, bus.end_out,
            bus.byte_done, bus.bit_cnt, bus.stuff_err, bus.align_err, bus.busy};
  endfunction

  task automatic add(input logic r, st, en, ab, d, input logic [10:0] e);
    vec_t v;
    v.r = r; v.st = st; v.en = en; v.ab = ab; v.d = d; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n               = v.r;
    bus.start_unstuffer = v.st;
    bus.end_unstuffer   = v.en;
    bus.abort           = v.ab;
    bus.s_in            = v.d;
    sb.push_back(v.e);
  endtask

  task automatic checkOutput(input int idx);
    logic [10:0] want;
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL vec%0d scoreboard empty got=%b", idx, actual());
    end else begin
      want = sb.pop_front();
      if (actual() !== want) begin
        bad++;
        $display("[TB] FAIL vec%0d outputs got=%b want=%b", idx, actual(), want);
      end
    end
  endtask

  initial begin
    logic [10:0] z, s, e0, e1;
    logic [7:0]  pa;
    logic [4:0]  pd;
    logic [15:0] pat;
    int          bd_cnt;

    bus.s_in = 1'b0; bus.start_unstuffer = 1'b0;
    bus.end_unstuffer = 1'b0; bus.abort = 1'b0;

    z  = ex(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    s  = ex(0, 0, 1, 0, 0, 3'd0, 0, 0, 1);
    e0 = ex(0, 0, 0, 1, 0, 3'd0, 0, 0, 0);
    e1 = ex(0, 0, 0, 1, 0, 3'd0, 0, 1, 0);

    // Reset, idle bit ignored, one full byte, clean end, idle end ignored.
    add(0, 0, 0, 0, 0, z);
    add(1, 0, 0, 0, 1, z);
    add(1, 1, 0, 0, 0, s);
    pa = 8'b1011_0010;
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, pa[7-i], ex(1, pa[7-i], 0, 0, (i == 7), 3'(i + 1), 0, 0, 1));
    add(1, 0, 1, 0, 0, e0);
    add(1, 0, 1, 0, 1, z);

    // Six 1s, stuffed 0 dropped, one more 1, end misaligned at bit_cnt 7.
    add(1, 1, 0, 0, 0, s);
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'(i + 1), 0, 0, 1));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 3'd6, 0, 0, 1));
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd7, 0, 0, 1));
    add(1, 0, 1, 0, 0, e1);

    // Seven 1s: stuffing violation kills the packet, later end is silent.
    add(1, 1, 0, 0, 0, s);
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'(i + 1), 0, 0, 1));
    add(1, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 3'd0, 1, 0, 0));
    add(1, 0, 1, 0, 0, z);

    // Five bits then end: alignment error.
    add(1, 1, 0, 0, 0, s);
    pd = 5'b01001;
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 0, pd[4-i], ex(1, pd[4-i], 0, 0, 0, 3'(i + 1), 0, 0, 1));
    add(1, 0, 1, 0, 0, e1);

    // Abort beats end; restart in RUN drops its bit and clears counters.
    add(1, 1, 0, 0, 0, s);
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd1, 0, 0, 1));
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd2, 0, 0, 1));
    add(1, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 3'd3, 0, 0, 1));
    add(1, 0, 1, 1, 0, z);
    add(1, 0, 0, 0, 1, z);
    add(1, 1, 0, 0, 0, s);
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd1, 0, 0, 1));
    add(1, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 3'd2, 0, 0, 1));
    add(1, 1, 0, 0, 1, s);
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd1, 0, 0, 1));
    add(1, 0, 1, 0, 0, e1);

    // Abort wins over start in IDLE; start+end in IDLE takes start;
    // end wins over a pending stuff slot; reset mid-packet clears everything.
    add(1, 1, 0, 1, 0, z);
    add(1, 1, 1, 0, 0, s);
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'(i + 1), 0, 0, 1));
    add(1, 0, 1, 0, 1, e1);
    add(1, 1, 0, 0, 0, s);
    add(1, 0, 0, 0, 1, ex(1, 1, 0, 0, 0, 3'd1, 0, 0, 1));
    add(0, 0, 0, 0, 1, z);
    add(1, 0, 0, 0, 0, z);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Two-byte stream: bit order via scoreboard, two byte_done pulses.
    applyStimulus('{r: 1'b1, st: 1'b1, en: 1'b0, ab: 1'b0, d: 1'b0, e: s});
    checkOutput(1000);
    pat = 16'hA5C3;
    bd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.start_unstuffer = 1'b0;
      bus.s_in = pat[15-i];
      bit_sb.push_back(pat[15-i]);
      @(posedge clk);
      #1;
      if (bus.byte_done) bd_cnt++;
      total++;
      if (!bus.bit_valid || bit_sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL stream%0d bit_valid got=%b want=1", i, bus.bit_valid);
      end else if (bus.s_out !== bit_sb.pop_front()) begin
        bad++;
        $display("[TB] FAIL stream%0d s_out got=%b want=%b", i, bus.s_out, pat[15-i]);
      end
    end
    total++;
    if (bd_cnt != 2 || bus.bit_cnt !== 3'd0) begin
      bad++;
      $display("[TB] FAIL stream byte_done count got=%0d want=2, bit_cnt got=%0d want=0",
               bd_cnt, bus.bit_cnt);
    end
    applyStimulus('{r: 1'b1, st: 1'b0, en: 1'b1, ab: 1'b0, d: 1'b0, e: e0});
    checkOutput(1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_unstuffer.md
Name: bit_unstuffer

Overview:
- Receive-path stage directly downstream of the NRZI decoder. Consumes one decoded bit per clock plus the decoder's start/end framing pulses.
- Removes the stuffed 0 that follows every run of MAX_ONES consecutive 1s and forwards only payload bits, each with a valid strobe.
- Tracks byte alignment, flags bit-stuffing and alignment errors, and feeds the packet/byte assembler.

Parameters:
- MAX_ONES, 6: run length of consecutive 1s after which the next bit must be a stuffed 0.
- CNT_W, 3: width of the ones-run counter; must hold MAX_ONES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- s_in  input  1  NRZI-decoded serial bit, one per clock.
- start_unstuffer  input  1  one-cycle pulse; packet begins, first data bit arrives next cycle.
- end_unstuffer  input  1  one-cycle pulse; s_in this cycle is not data, packet over.
- abort  input  1  kill current packet immediately.
- s_out  output  1  unstuffed data bit; meaningful only when bit_valid=1.
- bit_valid  output  1  s_out carries a payload bit this cycle.
- start_out  output  1  one-cycle pulse, packet start forwarded.
- end_out  output  1  one-cycle pulse, clean packet end forwarded.
- byte_done  output  1  pulses with the 8th, 16th, ... valid bit of a packet.
- bit_cnt  output  3  count of valid bits delivered in the current byte, 0..7.
- stuff_err  output  1  one-cycle pulse, a 1 arrived where a stuffed 0 was required.
- align_err  output  1  one-cycle pulse with end_out when bit_cnt!=0 at end.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, ones_cnt=0, bit_cnt=0. All outputs are 0.
- All outputs are registered. An event sampled at edge N is visible after edge N, giving 1-cycle latency from s_in to s_out.
- State IDLE:
  - s_in is ignored; bit_valid=0.
  - start_unstuffer=1 → RUN; start_out pulses; ones_cnt=0; bit_cnt=0.
- State RUN. Per cycle, priority is abort > end_unstuffer > start_unstuffer > data:
  - abort: → IDLE; ones_cnt and bit_cnt cleared; no end_out, no error pulses. abort has the same priority in IDLE.
  - end_unstuffer: → IDLE; s_in not forwarded. end_out pulses; align_err pulses if bit_cnt!=0; counters cleared. end_unstuffer also wins when ones_cnt==MAX_ONES.
  - start_unstuffer while in RUN: restart. start_out pulses, counters cleared, no end_out; the s_in bit that cycle is dropped.
  - Data, ones_cnt==MAX_ONES, s_in=0: stuffed bit dropped. bit_valid=0, ones_cnt=0, bit_cnt unchanged.
  - Data, ones_cnt==MAX_ONES, s_in=1: stuff_err pulses; → IDLE; counters cleared; bit not forwarded. The packet stays dead until the next start_unstuffer; a later end_unstuffer in IDLE produces no end_out.
  - Data, otherwise: bit_valid=1, s_out=s_in. ones_cnt increments if s_in=1, else clears. bit_cnt increments mod 8; byte_done pulses when bit_cnt wraps 7→0.
- end_unstuffer in IDLE is ignored. Simultaneous start and end in IDLE: end ignored, start taken.
- Width rules: ones_cnt saturates by construction (never exceeds MAX_ONES); bit_cnt wraps at 8.
- Reset mid-packet behaves as abort plus clearing of all outputs.

Test Plan:
- Reset, start pulse, bits 1,0,1,1,0,0,1,0, end pulse → start_out 1 cycle after start; 8 valid bits in same order at 1-cycle latency; byte_done with 8th bit; end_out=1, align_err=0.
- Bits 1,1,1,1,1,1,0,1 after start → six valid 1s; cycle with stuffed 0 has bit_valid=0; final 1 valid; bit_cnt=7; ones_cnt restarted after the stuffed 0.
- Bits 1×7 → six valid 1s; 7th produces stuff_err pulse and busy=0; subsequent end_unstuffer gives no end_out.
- Start, 5 data bits, end → end_out=1 and align_err=1 same cycle; bit_cnt returns to 0.
- Start, 3 bits, abort asserted concurrently with end_unstuffer → no end_out, no align_err; busy=0 next cycle; a new start then delivers bits normally.
- Six 1s, then end_unstuffer with s_in=1 → end_out=1, stuff_err=0 (end priority); rst_n=0 mid-packet → all outputs 0 on next cycle.
